// File: rtl/axis_dw_bank_pkg.sv
// Shared widths, field offsets and types for the conv-to-LReLU width down-converter.
package axis_dw_bank_pkg;

  localparam int WORD_WIDTH         = 32;
  localparam int UNITS              = 4;
  localparam int MEMBERS            = 12;
  localparam int KW_MAX             = 11;
  localparam int SW_MAX             = 4;
  localparam int BITS_KW2           = 3;
  localparam int BITS_SW            = 2;
  localparam int I_KW2              = 0;
  localparam int I_SW_1             = 3;
  localparam int TUSER_CONV_DW_BASE = 8;
  localparam int BITS_MEMBERS       = 4;
  localparam int BITS_OUT_SHIFT     = 4;
  localparam int CLR_WIDTH          = 4;
  localparam int I_CLR              = TUSER_CONV_DW_BASE;

  localparam int USER_WIDTH_IN  = MEMBERS*CLR_WIDTH + BITS_OUT_SHIFT + BITS_MEMBERS + TUSER_CONV_DW_BASE;
  localparam int USER_WIDTH_OUT = TUSER_CONV_DW_BASE + CLR_WIDTH;

  // Layout of s_user: {clr[MEMBERS-1:0], shift_b, shift_a, user_base}
  localparam int I_SHIFT_A  = TUSER_CONV_DW_BASE;
  localparam int I_SHIFT_B  = I_SHIFT_A + BITS_MEMBERS;
  localparam int I_CLR_IN   = I_SHIFT_B + BITS_OUT_SHIFT;

  localparam int MEMBER_WIDTH = UNITS * WORD_WIDTH;
  localparam int IDX_WIDTH    = $clog2(MEMBERS);
  // Group stride 2*kw2+1+sw_1 never exceeds 2*7+1+3 = 18
  localparam int STEP_WIDTH   = BITS_KW2 + 2;
  // Wide enough for base + step and idx + 1 without wrap
  localparam int SUM_WIDTH    = 8;

  typedef logic [UNITS-1:0][WORD_WIDTH-1:0] member_t;
  typedef logic [CLR_WIDTH-1:0]             clr_t;

  // Distance between the first members of consecutive output groups (K + S - 1)
  function automatic logic [STEP_WIDTH-1:0] group_step(input logic [BITS_KW2-1:0] kw2,
                                                       input logic [BITS_SW-1:0]  sw_1);
    return STEP_WIDTH'({kw2, 1'b1}) + STEP_WIDTH'(sw_1);
  endfunction

endpackage

// File: rtl/axis_dw_bank.sv
// AXI-Stream width down-converter: latches one wide beat of MEMBERS rows and
// replays the members selected by the kernel/stride shift fields, one per beat.
module axis_dw_bank
  import axis_dw_bank_pkg::*;
(
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic                              s_last,
  input  logic [MEMBERS*MEMBER_WIDTH-1:0]   s_data,
  input  logic [USER_WIDTH_IN-1:0]          s_user,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic                              m_last,
  output logic [MEMBER_WIDTH-1:0]           m_data,
  output logic [USER_WIDTH_OUT-1:0]         m_user
);

  localparam logic [SUM_WIDTH-1:0] MEMBERS_SUM = SUM_WIDTH'(MEMBERS);

  member_t                         bank [MEMBERS];
  clr_t                            clr_bank [MEMBERS];
  logic [TUSER_CONV_DW_BASE-1:0]   user_base;
  logic [BITS_MEMBERS-1:0]         shift_a;
  logic [BITS_OUT_SHIFT-1:0]       shift_b;
  logic [BITS_MEMBERS-1:0]         j;
  logic [BITS_OUT_SHIFT-1:0]       g;
  logic [IDX_WIDTH-1:0]            base;
  logic [IDX_WIDTH-1:0]            idx;
  logic                            last_flag;
  logic                            busy;

  logic [STEP_WIDTH-1:0]           step;
  logic [SUM_WIDTH-1:0]            next_col;
  logic [SUM_WIDTH-1:0]            next_row;
  logic                            col_end;
  logic                            row_end;
  logic                            final_beat;
  logic                            fire;
  logic                            accept;

  // Work out where the walk goes next and whether the current beat is the last one;
  // a walk stops as soon as the next member would fall off the end of the bank
  always_comb begin
    step       = group_step(user_base[I_KW2 +: BITS_KW2], user_base[I_SW_1 +: BITS_SW]);
    next_col   = SUM_WIDTH'(idx) + SUM_WIDTH'(1);
    next_row   = SUM_WIDTH'(base) + SUM_WIDTH'(step);
    col_end    = (j == shift_a);
    row_end    = (g == shift_b);
    final_beat = col_end ? (row_end || (next_row >= MEMBERS_SUM))
                         : (next_col >= MEMBERS_SUM);
    fire       = busy & m_ready;
    s_ready    = !aresetn & (!busy | (fire & final_beat));
    accept     = s_valid & s_ready;
  end

  // Capture a new wide beat, then advance the j/g counters one member per accepted output beat
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      busy      <= 1'b0;
      last_flag <= 1'b0;
      user_base <= '0;
      shift_a   <= '0;
      shift_b   <= '0;
      j         <= '0;
      g         <= '0;
      base      <= '0;
      idx       <= '0;
      for (int m = 0; m < MEMBERS; m++) begin
        bank[m]     <= '0;
        clr_bank[m] <= '0;
      end
    end else if (accept) begin
      busy      <= 1'b1;
      last_flag <= s_last;
      user_base <= s_user[0 +: TUSER_CONV_DW_BASE];
      shift_a   <= s_user[I_SHIFT_A +: BITS_MEMBERS];
      shift_b   <= s_user[I_SHIFT_B +: BITS_OUT_SHIFT];
      j         <= '0;
      g         <= '0;
      base      <= '0;
      idx       <= '0;
      for (int m = 0; m < MEMBERS; m++) begin
        bank[m]     <= s_data[m*MEMBER_WIDTH +: MEMBER_WIDTH];
        clr_bank[m] <= s_user[I_CLR_IN + m*CLR_WIDTH +: CLR_WIDTH];
      end
    end else if (fire) begin
      if (final_beat) begin
        busy <= 1'b0;
      end else if (!col_end) begin
        j   <= j + 1'b1;
        idx <= next_col[IDX_WIDTH-1:0];
      end else begin
        j    <= '0;
        g    <= g + 1'b1;
        base <= next_row[IDX_WIDTH-1:0];
        idx  <= next_row[IDX_WIDTH-1:0];
      end
    end
  end

  // Present the selected member straight from the bank so it stays put while stalled
  always_comb begin
    m_valid                             = busy;
    m_last                              = busy & last_flag & final_beat;
    m_data                              = bank[idx];
    m_user                              = '0;
    m_user[TUSER_CONV_DW_BASE-1:0]      = user_base;
    m_user[I_CLR +: CLR_WIDTH]          = clr_bank[idx];
  end

endmodule

// File: tb/tb_axis_dw_bank.sv
// Randomised and directed bench for axis_dw_bank against a queue-based beat model.
module tb_axis_dw_bank;
  import axis_dw_bank_pkg::*;

  logic                            clk = 1'b0;
  logic                            aresetn;
  logic                            s_valid;
  logic                            s_ready;
  logic                            s_last;
  logic [MEMBERS*MEMBER_WIDTH-1:0] s_data;
  logic [USER_WIDTH_IN-1:0]        s_user;
  logic                            m_valid;
  logic                            m_ready;
  logic                            m_last;
  logic [MEMBER_WIDTH-1:0]         m_data;
  logic [USER_WIDTH_OUT-1:0]       m_user;

  typedef struct {
    logic [MEMBER_WIDTH-1:0]   data;
    logic [USER_WIDTH_OUT-1:0] user;
    logic                      last;
  } beat_t;

  beat_t                          expQ[$];
  logic                           readyPat[$];
  logic                           readyRandom;
  logic                           inReset;
  int                             checkCount = 0;
  int                             passCount  = 0;
  int                             firedCount = 0;

  logic [WORD_WIDTH-1:0]          pktWord [MEMBERS][UNITS];
  logic [CLR_WIDTH-1:0]           pktClr  [MEMBERS];
  logic [TUSER_CONV_DW_BASE-1:0]  pktBase;
  int                             pktKw2, pktSw1, pktA, pktB;
  logic                           pktLast;

  axis_dw_bank dut (
    .aclk    (clk),
    .aresetn (aresetn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .s_data  (s_data),
    .s_user  (s_user),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .m_data  (m_data),
    .m_user  (m_user)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Model: walk groups g and columns j, member g*G+j, stopping at the first member past the bank
  task automatic modelAccept();
    int    grp;
    int    idx;
    bit    stop;
    beat_t b;
    grp  = 2*pktKw2 + 1 + pktSw1;
    stop = 0;
    for (int gi = 0; gi <= pktB && !stop; gi++) begin
      for (int ji = 0; ji <= pktA && !stop; ji++) begin
        idx = gi*grp + ji;
        if (idx >= MEMBERS) stop = 1;
        else begin
          for (int u = 0; u < UNITS; u++) b.data[u*WORD_WIDTH +: WORD_WIDTH] = pktWord[idx][u];
          b.user = {pktClr[idx], pktBase};
          b.last = 1'b0;
          expQ.push_back(b);
        end
      end
    end
    expQ[expQ.size()-1].last = pktLast;
  endtask

  // Scoreboard: compare every presented beat, then record acceptances into the model
  always @(negedge clk) begin
    if (!inReset) begin
      checkOutput("m_valid", m_valid, expQ.size() > 0);
      checkOutput("s_ready", s_ready, (expQ.size() == 0) || (m_ready && expQ.size() == 1));
      if (m_valid && m_ready) firedCount++;
      if (m_valid && expQ.size() > 0) begin
        checkOutput("m_data", m_data, expQ[0].data);
        checkOutput("m_user", m_user, expQ[0].user);
        checkOutput("m_last", m_last, expQ[0].last);
        if (m_ready) void'(expQ.pop_front());
      end
      if (s_valid && s_ready) modelAccept();
    end
  end

  // Downstream ready: scripted pattern first, otherwise random or held high
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (readyPat.size() > 0) m_ready = readyPat.pop_front();
      else if (readyRandom)    m_ready = 1'($urandom_range(0, 1));
      else                     m_ready = 1'b1;
    end
  end

  task automatic scrambleInputs();
    for (int w = 0; w < MEMBERS*UNITS; w++) s_data[w*WORD_WIDTH +: WORD_WIDTH] = $urandom;
    s_user = USER_WIDTH_IN'({$urandom, $urandom});
    s_last = 1'($urandom_range(0, 1));
  endtask

  task automatic applyReset();
    @(posedge clk); #1;
    aresetn = 1'b1;
    inReset = 1'b1;
    s_valid = 1'b0;
    expQ.delete();
    readyPat.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_last",  m_last,  0);
    checkOutput("rst_m_data",  m_data,  0);
    checkOutput("rst_m_user",  m_user,  0);
    checkOutput("rst_s_ready", s_ready, 0);
    @(posedge clk); #1;
    aresetn = 1'b0;
    inReset = 1'b0;
  endtask

  task automatic applyStimulus(input int kw2, input int sw1, input int a, input int b,
                               input logic last, input logic randomData);
    int waited;
    pktKw2  = kw2;
    pktSw1  = sw1;
    pktA    = a;
    pktB    = b;
    pktLast = last;
    pktBase = {3'($urandom), 2'(sw1), 3'(kw2)};
    for (int m = 0; m < MEMBERS; m++) begin
      for (int u = 0; u < UNITS; u++)
        pktWord[m][u] = randomData ? $urandom : WORD_WIDTH'(m*10 + u + 1);
      pktClr[m] = randomData ? CLR_WIDTH'($urandom) : CLR_WIDTH'(m + 1);
    end
    for (int m = 0; m < MEMBERS; m++) begin
      for (int u = 0; u < UNITS; u++)
        s_data[m*MEMBER_WIDTH + u*WORD_WIDTH +: WORD_WIDTH] = pktWord[m][u];
      s_user[I_CLR_IN + m*CLR_WIDTH +: CLR_WIDTH] = pktClr[m];
    end
    s_user[0 +: TUSER_CONV_DW_BASE]      = pktBase;
    s_user[I_SHIFT_A +: BITS_MEMBERS]    = BITS_MEMBERS'(a);
    s_user[I_SHIFT_B +: BITS_OUT_SHIFT]  = BITS_OUT_SHIFT'(b);
    s_last  = last;
    s_valid = 1'b1;
    waited  = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      waited++;
      if (waited > 300) begin
        checkOutput("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    scrambleInputs();
  endtask

  task automatic waitIdle(input string tag);
    int waited;
    waited = 0;
    forever begin
      @(negedge clk);
      if (expQ.size() == 0 && !m_valid) break;
      waited++;
      if (waited > 500) begin
        checkOutput({tag, "_drain_timeout"}, 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic runDirected(input string tag, input int kw2, input int sw1, input int a,
                             input int b, input logic last, input int expLen);
    int start;
    start = firedCount;
    applyStimulus(kw2, sw1, a, b, last, 1'b0);
    waitIdle(tag);
    checkOutput({tag, "_len"}, firedCount - start, expLen);
  endtask

  initial begin
    int start;
    aresetn     = 1'b1;
    inReset     = 1'b1;
    readyRandom = 1'b0;
    s_valid     = 1'b0;
    s_last      = 1'b0;
    s_data      = '0;
    s_user      = '0;
    applyReset();

    // Directed shapes with the indexable data pattern
    repeat (3) readyPat.push_back(1'b0);
    runDirected("K1S1",      0, 0, 11, 0, 1'b1, 12);
    runDirected("K3S1_mid",  1, 0, 0,  3, 1'b1, 4);
    runDirected("K3S1_end",  1, 0, 1,  3, 1'b1, 8);
    runDirected("K11S4",     5, 3, 7,  0, 1'b1, 8);
    runDirected("K11S4_b1",  5, 3, 7,  1, 1'b1, 8);

    // Backpressure pattern across a 12-beat packet
    foreach (readyPat[i]) readyPat[i] = readyPat[i];
    for (int i = 0; i < 4;  i++) readyPat.push_back(1'b0);
    for (int i = 0; i < 3;  i++) readyPat.push_back(1'b1);
    for (int i = 0; i < 20; i++) readyPat.push_back(1'b0);
    for (int i = 0; i < 4;  i++) readyPat.push_back(1'b1);
    for (int i = 0; i < 2;  i++) readyPat.push_back(1'b0);
    runDirected("bp", 0, 0, 11, 0, 1'b1, 12);

    // Back-to-back: second packet waits on s_valid while the first drains; no s_last on it
    start = firedCount;
    applyStimulus(1, 0, 0, 3, 1'b1, 1'b0);
    applyStimulus(1, 0, 1, 3, 1'b0, 1'b0);
    waitIdle("b2b");
    checkOutput("b2b_len", firedCount - start, 12);

    // Random shapes, data and downstream stalls
    readyRandom = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
      applyStimulus($urandom_range(0, KW_MAX/2), $urandom_range(0, SW_MAX-1),
                    $urandom_range(0, MEMBERS-1), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'b1);
    end
    waitIdle("rand");
    readyRandom = 1'b0;

    // Reset in the middle of a sequence, then a clean packet afterwards
    applyStimulus(0, 0, 11, 0, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    applyReset();
    repeat (3) @(posedge clk);
    #1;
    runDirected("post_rst", 1, 0, 0, 3, 1'b1, 4);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
